// File: rtl/prim_secded_inv_64_57_enc_stream.sv
// Streaming inverted SECDED(64,57) Hsiao encoder with a main + skid buffer.
// Ports: clk_i, rst_i (sync, active-high); in_valid_i/in_ready_o/in_data_i[56:0];
//   out_valid_o/out_ready_i/out_data_o[63:0]; enc_cnt_o[CNT_W-1:0] (saturating);
//   inj_mask_i[63:0] only when SECDED_ENC_ERR_INJ_EN is defined.
module prim_secded_inv_64_57_enc_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [56:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_data_o,
  output logic [CNT_W-1:0] enc_cnt_o
`ifdef SECDED_ENC_ERR_INJ_EN
  ,
  input  logic [63:0]      inj_mask_i
`endif
);

  localparam logic [56:0] M0 = 57'h0103fff800007fff;
  localparam logic [56:0] M1 = 57'h017c1ff801ff801f;
  localparam logic [56:0] M2 = 57'h01bde1f87e0781e1;
  localparam logic [56:0] M3 = 57'h01deee3b8e388e22;
  localparam logic [56:0] M4 = 57'h01ef76cdb2c93244;
  localparam logic [56:0] M5 = 57'h01f7bb56d5525488;
  localparam logic [56:0] M6 = 57'h01fbdda769a46910;
  localparam logic [63:0] INV = 64'h5400000000000000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] skid;
  logic [6:0]  par;
  logic [63:0] cw;
  logic        acc;
  logic        take;

  assign acc  = in_valid_i & in_ready_o;
  assign take = out_valid_o & out_ready_i;

  // Encode ahead of the register so the output is a pure flop.
  always_comb begin
    par    = '0;
    par[0] = ^(in_data_i & M0);
    par[1] = ^(in_data_i & M1);
    par[2] = ^(in_data_i & M2);
    par[3] = ^(in_data_i & M3);
    par[4] = ^(in_data_i & M4);
    par[5] = ^(in_data_i & M5);
    par[6] = ^(in_data_i & M6);
    cw     = {par, in_data_i} ^ INV;
`ifdef SECDED_ENC_ERR_INJ_EN
    cw     = cw ^ inj_mask_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      out_data_o  <= '0;
      skid        <= '0;
      enc_cnt_o   <= '0;
    end else begin
      if (take && (enc_cnt_o != '1)) begin
        enc_cnt_o <= enc_cnt_o + CNT_W'(1);
      end
      unique case (state)
        EMPTY: begin
          if (acc) begin
            out_data_o  <= cw;
            out_valid_o <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (acc && take) begin
            out_data_o <= cw;
          end else if (take) begin
            out_valid_o <= 1'b0;
            state       <= EMPTY;
          end else if (acc) begin
            // Main is stalled: park the new word, stop accepting.
            skid       <= cw;
            in_ready_o <= 1'b0;
            state      <= FULL;
          end
        end
        FULL: begin
          if (take) begin
            out_data_o <= skid;
            in_ready_o <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule
